// File: rtl/aes_fetch_seq.sv
// Fetch stage: owns the PC, addresses instruction memory and sequences multi-beat AES macro-ops.
// Optional AES_FETCH_MISALIGN_EN rejects misaligned redirects and flags them on misalign_err.
module aes_fetch_seq #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned AES_BEATS  = 4,
  parameter logic [6:0]  AES_OPCODE = 7'b0001011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        load_temp,
  output logic        plus1,
  output logic        busy
`ifdef AES_FETCH_MISALIGN_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(AES_BEATS - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_AES_SEQ = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             is_aes;
  logic             redirect_rej;
  logic             redirect_take;
  logic             hold;

  assign is_aes = (imem_rdata[6:0] == AES_OPCODE);

`ifdef AES_FETCH_MISALIGN_EN
  logic unused_rdata;
  assign unused_rdata = ^imem_rdata[31:7];
  assign redirect_rej = redirect_valid & (|redirect_pc[1:0]);
`else
  logic unused_bits;
  assign unused_bits  = ^{imem_rdata[31:7], redirect_pc[1:0]};
  assign redirect_rej = 1'b0;
`endif

  assign redirect_take = redirect_valid & ~redirect_rej;
  // A rejected redirect freezes the stage just like a stall, keeping any AES op alive.
  assign hold          = stall | redirect_rej;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state and beat flags; priority start > redirect > stall > advance
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    beat_cnt_d = beat_cnt_q;
    load_temp  = 1'b0;
    plus1      = 1'b0;

    if (!start) begin
      state_d    = ST_IDLE;
      pc_d       = RESET_PC;
      beat_cnt_d = '0;
    end else if (redirect_take) begin
      state_d    = ST_FETCH;
      pc_d       = {redirect_pc[31:2], 2'b00};
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!hold) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          load_temp = is_aes;
          if (!hold) begin
            if (is_aes) begin
              state_d    = ST_AES_SEQ;
              beat_cnt_d = CNT_W'(1);
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
        ST_AES_SEQ: begin
          plus1 = 1'b1;
          if (!hold) begin
            if (beat_cnt_q == LAST_BEAT) begin
              state_d    = ST_FETCH;
              pc_d       = pc_q + 32'd4;
              beat_cnt_d = '0;
            end else begin
              beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          beat_cnt_d = '0;
        end
      endcase
    end
  end

`ifdef AES_FETCH_MISALIGN_EN
  // One-cycle pulse after a rejected redirect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_err <= 1'b0;
    else        misalign_err <= start & redirect_rej;
  end
`endif

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign busy      = (state_q == ST_AES_SEQ);

endmodule

// File: tb/tb_aes_fetch_seq.sv
// Self-checking bench for aes_fetch_seq: directed scenarios plus randomized run against a dwell-based model.
// Build with +define+AES_FETCH_MISALIGN_EN to also exercise misaligned-redirect rejection.
module tb_aes_fetch_seq;

  localparam int unsigned BEATS   = 4;
  localparam logic [31:0] AES_OP  = 32'h0000_000B;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        load_temp;
  logic        plus1;
  logic        busy;
`ifdef AES_FETCH_MISALIGN_EN
  logic        misalign_err;
`endif

  logic [31:0] imem [256];
  int n_checks = 0;
  int n_fail   = 0;

  aes_fetch_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .load_temp     (load_temp),
    .plus1         (plus1),
    .busy          (busy)
`ifdef AES_FETCH_MISALIGN_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  assign imem_rdata = imem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 256; i++) imem[i] = NOP;
    @(negedge clk);
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4: got %h expected %h", pc_plus4, 32'h4); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, 32'h0); end
    n_checks++; if ({load_temp, plus1, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {load_temp, plus1, busy}); end
    next_cycle();
  endtask

  task automatic test_nop_aes();
    logic [31:0] e_pc [8] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC};
    logic        e_lt [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    logic        e_p1 [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    imem[2] = AES_OP;
    reset = 1'b1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++; if (pc !== e_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, e_pc[i]); end
      n_checks++; if (pc_plus4 !== e_pc[i] + 32'd4) begin n_fail++; $display("FAIL seq_pc_plus4[%0d]: got %h expected %h", i, pc_plus4, e_pc[i] + 32'd4); end
      n_checks++; if (load_temp !== e_lt[i]) begin n_fail++; $display("FAIL seq_load_temp[%0d]: got %b expected %b", i, load_temp, e_lt[i]); end
      n_checks++; if (plus1 !== e_p1[i]) begin n_fail++; $display("FAIL seq_plus1[%0d]: got %b expected %b", i, plus1, e_p1[i]); end
      n_checks++; if (busy !== e_p1[i]) begin n_fail++; $display("FAIL seq_busy[%0d]: got %b expected %b", i, busy, e_p1[i]); end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic        e_st [7] = '{0, 0, 1, 1, 0, 0, 0};
    logic [31:0] e_pc [7] = '{32'h8, 32'h8, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC};
    logic        e_lt [7] = '{1, 0, 0, 0, 0, 0, 0};
    logic        e_p1 [7] = '{0, 1, 1, 1, 1, 1, 0};
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    @(negedge clk);
    n_checks++; if ({load_temp, plus1} !== 2'b00) begin n_fail++; $display("FAIL stall_redir_flags: got %b expected 00", {load_temp, plus1}); end
    next_cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      stall = e_st[i];
      @(negedge clk);
      n_checks++; if (pc !== e_pc[i]) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pc, e_pc[i]); end
      n_checks++; if (load_temp !== e_lt[i]) begin n_fail++; $display("FAIL stall_load_temp[%0d]: got %b expected %b", i, load_temp, e_lt[i]); end
      n_checks++; if (plus1 !== e_p1[i]) begin n_fail++; $display("FAIL stall_plus1[%0d]: got %b expected %b", i, plus1, e_p1[i]); end
      next_cycle();
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    next_cycle();
    redirect_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    n_checks++; if (plus1 !== 1'b1) begin n_fail++; $display("FAIL redir_pre_plus1: got %b expected 1", plus1); end
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100; stall = 1'b1;
    @(negedge clk);
    n_checks++; if ({load_temp, plus1} !== 2'b00) begin n_fail++; $display("FAIL redir_flags: got %b expected 00", {load_temp, plus1}); end
    next_cycle();
    redirect_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL redir_pc: got %h expected %h", pc, 32'h100); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL redir_busy: got %b expected 0", busy); end
    next_cycle();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'hFFFF_FFFC); end
    n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4: got %h expected %h", pc_plus4, 32'h0); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next_pc: got %h expected %h", pc, 32'h0); end
    next_cycle();
  endtask

  task automatic test_abort_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    next_cycle();
    redirect_valid = 1'b0;
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    n_checks++; if ({load_temp, plus1, busy} !== 3'b001) begin n_fail++; $display("FAIL abort_flags: got %b expected 001", {load_temp, plus1, busy}); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (pc !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_pc_busy: got %h/%b expected 00000000/0", pc, busy); end
    next_cycle();
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h41;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL abort_redir_pc: got %h expected %h", pc, 32'h40); end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL async_reset_pc: got %h/%h expected 00000000/00000004", pc, pc_plus4); end
    n_checks++; if ({load_temp, plus1, busy} !== 3'b000) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 000", {load_temp, plus1, busy}); end
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

`ifdef AES_FETCH_MISALIGN_EN
  task automatic test_misalign();
    logic [31:0] pc_before;
    @(negedge clk);
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_idle: got %b expected 0", misalign_err); end
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    pc_before = pc;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (pc !== pc_before) begin n_fail++; $display("FAIL misalign_pc: got %h expected %h", pc, pc_before); end
    n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_err_set: got %b expected 1", misalign_err); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL misalign_err_clear: got %b expected 0", misalign_err); end
    next_cycle();
  endtask
`endif

  // Model: an instruction occupies the PC for BEATS unstalled cycles if AES, else one.
  task automatic test_random();
    logic        m_act;
    logic [31:0] m_pc;
    int          m_held;
    logic        aes_here;
    logic        e_lt, e_p1, e_busy;
    int          need;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 99) < 20) imem[i] = {$urandom} & 32'hFFFF_FF80 | AES_OP;
      else                            imem[i] = {$urandom} & 32'hFFFF_FF80 | NOP;
    end
    start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    next_cycle();
    m_act = 1'b0; m_pc = 32'h0; m_held = 0;
    for (int c = 0; c < 600; c++) begin
      start          = ($urandom_range(0, 99) < 97);
      stall          = ($urandom_range(0, 99) < 20);
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_pc    = $urandom;
`ifdef AES_FETCH_MISALIGN_EN
      redirect_pc[1:0] = 2'b00;
`endif
      aes_here = (imem[m_pc[9:2]][6:0] == AES_OP[6:0]);
      e_busy   = (m_held != 0);
      e_p1     = start && !redirect_valid && (m_held != 0);
      e_lt     = start && !redirect_valid && m_act && (m_held == 0) && aes_here;
      @(negedge clk);
      n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h expected %h", c, pc, m_pc); end
      n_checks++; if (pc_plus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rand_pc_plus4[%0d]: got %h expected %h", c, pc_plus4, m_pc + 32'd4); end
      n_checks++; if (load_temp !== e_lt) begin n_fail++; $display("FAIL rand_load_temp[%0d]: got %b expected %b", c, load_temp, e_lt); end
      n_checks++; if (plus1 !== e_p1) begin n_fail++; $display("FAIL rand_plus1[%0d]: got %b expected %b", c, plus1, e_p1); end
      n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy, e_busy); end
      if (!start) begin
        m_act = 1'b0; m_pc = 32'h0; m_held = 0;
      end else if (redirect_valid) begin
        m_act = 1'b1; m_pc = redirect_pc & 32'hFFFF_FFFC; m_held = 0;
      end else if (!stall) begin
        if (!m_act) m_act = 1'b1;
        else begin
          m_held++;
          need = aes_here ? BEATS : 1;
          if (m_held == need) begin
            m_pc   = m_pc + 32'd4;
            m_held = 0;
          end
        end
      end
      next_cycle();
    end
    start = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nop_aes();
    test_stall();
    test_redirect();
    test_wrap();
    test_abort_reset();
`ifdef AES_FETCH_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_fetch_seq.md
Name: aes_fetch_seq

Overview:
- Fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives instruction-memory addressing.
- Generates the per-beat sequencing flags (load_temp, plus1) for the multi-beat AES custom instruction; the PC is held while the AES op expands.
- Outputs pc, pc_plus4, load_temp and plus1 feed the IF/ID register's pc_in, pc_plus4_in, load_temp_in and plus1_in; it shares that register's start gating.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset and while start=0
- AES_BEATS, 4, total beats per AES instruction (1 load_temp beat + AES_BEATS-1 plus1 beats); legal range 2..16
- AES_OPCODE, 7'b0001011, opcode field (inst[6:0]) marking an AES macro-op (custom-0)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  core enable; 0 = hold in IDLE with PC at RESET_PC
- stall  input  1  downstream hazard; freeze all state this cycle
- redirect_valid  input  1  branch/jump redirect from execute
- redirect_pc  input  32  redirect target
- imem_addr  output  32  instruction memory address (= pc), combinational
- imem_rdata  input  32  instruction word, combinational read of imem_addr
- pc  output  32  current PC (pc_q)
- pc_plus4  output  32  pc_q + 4, modulo 2^32
- load_temp  output  1  first beat of an AES op
- plus1  output  1  continuation beat of an AES op (advance round index)
- busy  output  1  1 while in AES_SEQ

Behaviour:
- Registered state: pc_q[31:0], state {IDLE, FETCH, AES_SEQ}, beat_cnt[3:0].
- Reset (reset=0, async): pc_q=RESET_PC, state=IDLE, beat_cnt=0.
  - Outputs during reset: pc=RESET_PC, pc_plus4=RESET_PC+4, load_temp=0, plus1=0, busy=0.
- pc, pc_plus4, imem_addr and busy are derived from registered state. load_temp is combinational from state and imem_rdata.
- Priority each cycle: start=0 > redirect_valid > stall > normal advance.
- start=0:
  - Next state=IDLE, pc_q<=RESET_PC, beat_cnt<=0.
  - load_temp=plus1=0 combinationally.
  - Deasserting start mid-AES aborts the sequence.
- IDLE with start=1: next state FETCH; pc_q unchanged (=RESET_PC).
- Redirect (redirect_valid=1 with start=1):
  - pc_q<={redirect_pc[31:2],2'b00}, state<=FETCH, beat_cnt<=0.
  - load_temp=plus1=0 this cycle.
  - Redirect wins over stall and aborts an in-progress AES sequence.
- stall=1 (no redirect, start=1):
  - pc_q, state and beat_cnt hold.
  - load_temp/plus1 keep their pre-stall values, since imem_addr is unchanged.
- FETCH, no stall or redirect:
  - If imem_rdata[6:0]==AES_OPCODE: load_temp=1 this cycle; state<=AES_SEQ; beat_cnt<=1; pc_q holds.
  - Otherwise: pc_q<=pc_q+4 (wraps 32'hFFFF_FFFC -> 0).
- AES_SEQ: plus1=1 and busy=1 every non-redirected cycle.
  - Not stalled and beat_cnt==AES_BEATS-1: pc_q<=pc_q+4, state<=FETCH, beat_cnt<=0.
  - Otherwise, not stalled: beat_cnt<=beat_cnt+1.
- load_temp and plus1 are never both 1.
- Total PC dwell on an unstalled AES instruction = AES_BEATS cycles.

Optional Feature:
- Macro: AES_FETCH_MISALIGN_EN.
- Defined:
  - Adds output port misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 is rejected: pc_q and state hold, any AES sequence continues.
  - misalign_err is registered high for exactly the following cycle.
- Undefined:
  - No port.
  - Low bits are silently forced to 00 and the redirect is taken.

Test Plan:
- Reset, then start=1; imem returns 32'h00000013 (NOP) -> after 1 IDLE->FETCH cycle, pc sequences 0,4,8,12 on consecutive cycles; pc_plus4 = pc+4; load_temp=plus1=0.
- At pc=8, imem_rdata=32'h0000000B (AES, AES_BEATS=4) -> load_temp=1 for 1 cycle, plus1=1 for 3 cycles, pc=8 for 4 cycles, then pc=12; busy=1 during the 3 plus1 cycles.
- stall=1 for 2 cycles during the 2nd AES beat -> plus1 stays 1, pc stays 8, beat completion delayed by exactly 2 cycles.
- redirect_valid=1 with redirect_pc=32'h100 during AES_SEQ (with stall=1 simultaneously) -> next pc=32'h100, state FETCH, plus1=0 on the redirect cycle.
- Start with pc_q=32'hFFFF_FFFC and a NOP -> pc wraps to 0; pc_plus4 at 32'hFFFF_FFFC reads 0.
- Drop start mid-AES, then assert async reset mid-cycle -> pc returns to RESET_PC immediately on reset; load_temp/plus1/busy=0. With AES_FETCH_MISALIGN_EN, redirect_pc=32'h102 -> pc unchanged and misalign_err=1 for exactly 1 cycle.
